// File: rtl/sub16sat_pipe.sv
// Two-stage pipelined saturating subtractor r = a - b - bin with 8-bit / hi-nibble field split and clamp.
// Latency: operand accepted at edge k is presented on out_valid/r after edge k+1; one result per cycle.
// Backpressure: out_ready low holds r/bo/sat_flag; in_ready drops only when both stages are occupied.
//
// Ports:
//   sys_clk, rst        clock (rising edge) and synchronous active-high reset
//   in_valid/in_ready   operand handshake for a, b, bin, sat, eightbit, hicinh
//   out_valid/out_ready result handshake for r, bo, sat_flag
//   sat_count, cnt_clr  saturating count of clamped results delivered, synchronous clear
module sub16sat_pipe #(
    parameter int CNTW = 8
) (
    input  logic            sys_clk,
    input  logic            rst,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [15:0]     a,
    input  logic [15:0]     b,
    input  logic            bin,
    input  logic            sat,
    input  logic            eightbit,
    input  logic            hicinh,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [15:0]     r,
    output logic            bo,
    output logic            sat_flag,
    output logic [CNTW-1:0] sat_count,
    input  logic            cnt_clr
);

    // ------------------------------------------------------------------
    // Handshake / pipeline control
    // ------------------------------------------------------------------
    logic s1_valid;
    logic s2_valid;
    logic s1_load;
    logic s2_load;
    logic out_hs;

    assign in_ready  = ~rst & (~s1_valid | ~s2_valid | out_ready);
    assign s1_load   = in_valid & in_ready;
    assign s2_load   = s1_valid & (~s2_valid | out_ready);
    assign out_valid = s2_valid;
    assign out_hs    = s2_valid & out_ready;

    // ------------------------------------------------------------------
    // Stage 1: low byte of a + ~b + ~bin. c8 is the raw carry out of bit 7,
    // kept separately because it is both the 8-bit-mode saturation carry and
    // (when not in 8-bit mode) the carry into bit 8.
    // ------------------------------------------------------------------
    logic [8:0] lo_sum;
    assign lo_sum = {1'b0, a[7:0]} + {1'b0, ~b[7:0]} + {8'd0, ~bin};

    logic [7:0] s1_a_hi;
    logic [7:0] s1_b_hi;
    logic [7:0] s1_lo;
    logic       s1_c8;
    logic       s1_b7;
    logic       s1_sat;
    logic       s1_eb;
    logic       s1_hc;

    always_ff @(posedge sys_clk) begin
        if (rst) begin
            s1_valid <= 1'b0;
            s1_a_hi  <= 8'd0;
            s1_b_hi  <= 8'd0;
            s1_lo    <= 8'd0;
            s1_c8    <= 1'b0;
            s1_b7    <= 1'b0;
            s1_sat   <= 1'b0;
            s1_eb    <= 1'b0;
            s1_hc    <= 1'b0;
        end else begin
            if (s1_load) begin
                s1_valid <= 1'b1;
                s1_a_hi  <= a[15:8];
                s1_b_hi  <= b[15:8];
                s1_lo    <= lo_sum[7:0];
                s1_c8    <= lo_sum[8];
                s1_b7    <= b[7];
                s1_sat   <= sat;
                s1_eb    <= eightbit;
                s1_hc    <= hicinh;
            end else if (s2_load) begin
                s1_valid <= 1'b0;
            end
        end
    end

    // ------------------------------------------------------------------
    // Stage 2 combinational: bits 8-11 and 12-15 with field-boundary carries.
    // A forced carry of 1 makes the upper field an independent a_f - b_f.
    // ------------------------------------------------------------------
    logic       cin8;
    logic       cin12;
    logic [4:0] mid_sum;
    logic [4:0] hi_sum;
    logic       c16;
    logic       btop;
    logic       ctop;
    logic       do_sat;
    logic [7:0] lo_res;
    logic [7:0] hi_res;

    assign cin8    = s1_eb | s1_c8;
    assign mid_sum = {1'b0, s1_a_hi[3:0]} + {1'b0, ~s1_b_hi[3:0]} + {4'd0, cin8};
    assign cin12   = s1_hc | mid_sum[4];
    assign hi_sum  = {1'b0, s1_a_hi[7:4]} + {1'b0, ~s1_b_hi[7:4]} + {4'd0, cin12};
    assign c16     = hi_sum[4];

    // Overflow when the delta sign agrees with the carry: b >= 0 with a borrow
    // (clamp to 0) or b < 0 with a carry (clamp to ones); ctop is the clamp value.
    assign btop   = s1_eb ? s1_b7 : s1_b_hi[7];
    assign ctop   = s1_eb ? s1_c8 : c16;
    assign do_sat = s1_sat & ~(btop ^ ctop);

    // In 8-bit mode the upper byte always keeps its raw field difference.
    assign lo_res = do_sat ? {8{ctop}} : s1_lo;
    assign hi_res = (do_sat & ~s1_eb) ? {8{ctop}} : {hi_sum[3:0], mid_sum[3:0]};

    // ------------------------------------------------------------------
    // Stage 2 registers: output holding register, only reloaded on advance so
    // r/bo/sat_flag stay stable while the consumer stalls.
    // ------------------------------------------------------------------
    always_ff @(posedge sys_clk) begin
        if (rst) begin
            s2_valid <= 1'b0;
            r        <= 16'h0000;
            bo       <= 1'b0;
            sat_flag <= 1'b0;
        end else begin
            if (s2_load) begin
                s2_valid <= 1'b1;
                r        <= {hi_res, lo_res};
                bo       <= ~c16;
                sat_flag <= do_sat;
            end else if (out_ready) begin
                s2_valid <= 1'b0;
            end
        end
    end

    // ------------------------------------------------------------------
    // Saturation event counter: counts delivered clamped results, sticks at
    // all-ones; clear has priority over a coincident increment.
    // ------------------------------------------------------------------
    always_ff @(posedge sys_clk) begin
        if (rst || cnt_clr) begin
            sat_count <= '0;
        end else if (out_hs && sat_flag && !(&sat_count)) begin
            sat_count <= sat_count + 1'b1;
        end
    end

endmodule

// File: tb/tb_sub16sat_pipe.sv
module tb_sub16sat_pipe;

    logic        sys_clk;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [15:0] a;
    logic [15:0] b;
    logic        bin;
    logic        sat;
    logic        eightbit;
    logic        hicinh;
    logic        out_valid;
    logic        out_ready;
    logic [15:0] r;
    logic        bo;
    logic        sat_flag;
    logic [7:0]  sat_count;
    logic        cnt_clr;

    int n_cmp;
    int n_err;

    sub16sat_pipe #(.CNTW(8)) dut (
        .sys_clk   (sys_clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .bin       (bin),
        .sat       (sat),
        .eightbit  (eightbit),
        .hicinh    (hicinh),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .r         (r),
        .bo        (bo),
        .sat_flag  (sat_flag),
        .sat_count (sat_count),
        .cnt_clr   (cnt_clr)
    );

    initial sys_clk = 1'b0;
    always #5 sys_clk = ~sys_clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Advance to 1 time unit after the next rising edge.
    task automatic tick();
        @(posedge sys_clk);
        #1;
    endtask

    // One isolated operation through an empty pipeline with out_ready high.
    task automatic run_op(input string tag,
                          input logic [15:0] ta, input logic [15:0] tb_v, input logic tbin,
                          input logic tsat, input logic teb, input logic thc,
                          input logic [15:0] er, input logic ebo, input logic esf);
        a = ta; b = tb_v; bin = tbin; sat = tsat; eightbit = teb; hicinh = thc;
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        a = 16'hDEAD; b = 16'hBEEF; bin = 1'b1; sat = ~tsat; eightbit = ~teb; hicinh = ~thc;
        check({tag, "_early"}, {31'd0, out_valid}, 32'd0);
        tick();
        check({tag, "_vld"}, {31'd0, out_valid}, 32'd1);
        check({tag, "_r"},   {16'd0, r},         {16'd0, er});
        check({tag, "_bo"},  {31'd0, bo},        {31'd0, ebo});
        check({tag, "_sf"},  {31'd0, sat_flag},  {31'd0, esf});
        tick();
        check({tag, "_drain"}, {31'd0, out_valid}, 32'd0);
    endtask

    logic [15:0] exp_r [6];
    int sent;
    int got;
    int cyc;
    bit acc;
    bit take;

    initial begin
        n_cmp = 0; n_err = 0;
        rst = 1'b1; in_valid = 1'b0; out_ready = 1'b1; cnt_clr = 1'b0;
        a = 16'h0; b = 16'h0; bin = 1'b0; sat = 1'b0; eightbit = 1'b0; hicinh = 1'b0;

        // Reset state
        tick();
        tick();
        check("rst_in_ready",  {31'd0, in_ready},  32'd0);
        check("rst_out_valid", {31'd0, out_valid}, 32'd0);
        check("rst_r",         {16'd0, r},         32'd0);
        check("rst_bo",        {31'd0, bo},        32'd0);
        check("rst_sat_flag",  {31'd0, sat_flag},  32'd0);
        check("rst_sat_count", {24'd0, sat_count}, 32'd0);
        rst = 1'b0;
        #1;
        check("post_rst_in_ready", {31'd0, in_ready}, 32'd1);
        tick();

        // Directed arithmetic vectors
        run_op("unclamped",   16'h1234, 16'h0034, 1'b0, 1'b1, 1'b0, 1'b0, 16'h1200, 1'b0, 1'b0);
        run_op("clamp0",      16'h0010, 16'h0020, 1'b0, 1'b1, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b1);
        run_op("nosat_wrap",  16'h0010, 16'h0020, 1'b0, 1'b0, 1'b0, 1'b0, 16'hFFF0, 1'b1, 1'b0);
        run_op("clamp_hi",    16'hFFF0, 16'hFFE0, 1'b0, 1'b1, 1'b0, 1'b0, 16'hFFFF, 1'b0, 1'b1);
        run_op("borrow_in",   16'h00FF, 16'h0001, 1'b1, 1'b1, 1'b0, 1'b0, 16'h00FD, 1'b0, 1'b0);
        run_op("eightbit",    16'h5502, 16'h1105, 1'b0, 1'b1, 1'b1, 1'b0, 16'h4400, 1'b0, 1'b1);
        run_op("hicinh",      16'h1000, 16'h0001, 1'b0, 1'b0, 1'b0, 1'b1, 16'h1FFF, 1'b0, 1'b0);
        // 8-bit mode, negative byte delta with carry: low byte clamps to 0xFF, high byte raw
        run_op("eb_clamp_hi", 16'h20F0, 16'h10E0, 1'b0, 1'b1, 1'b1, 1'b0, 16'h10FF, 1'b0, 1'b1);
        check("count_after_directed", {24'd0, sat_count}, 32'd4);

        // Back-pressure burst: 6 operands, out_ready low in cycles 3..5
        for (int i = 0; i < 6; i++) exp_r[i] = 16'h1000 + 16'h0111 * i[15:0] - i[15:0];
        sent = 0; got = 0; cyc = 0;
        sat = 1'b0; eightbit = 1'b0; hicinh = 1'b0; bin = 1'b0;
        while (got < 6 && cyc < 40) begin
            out_ready = !(cyc >= 3 && cyc < 6);
            in_valid  = (sent < 6);
            a = 16'h1000 + 16'h0111 * sent[15:0];
            b = sent[15:0];
            #1;
            acc  = in_valid & in_ready;
            take = out_valid & out_ready;
            if (cyc >= 3 && cyc < 6) begin
                check($sformatf("bp_in_ready_c%0d", cyc), {31'd0, in_ready},  32'd0);
                check($sformatf("bp_hold_vld_c%0d", cyc), {31'd0, out_valid}, 32'd1);
                check($sformatf("bp_hold_r_c%0d", cyc),   {16'd0, r},         {16'd0, exp_r[got]});
            end
            if (take) begin
                check($sformatf("bp_r%0d", got), {16'd0, r}, {16'd0, exp_r[got]});
                got++;
            end
            if (acc) sent++;
            tick();
            cyc++;
        end
        in_valid = 1'b0; out_ready = 1'b1;
        check("bp_results", got, 32'd6);
        tick();
        check("bp_no_dup", {31'd0, out_valid}, 32'd0);
        tick();

        // cnt_clr coincident with a clamped handshake
        a = 16'h0000; b = 16'h0001; bin = 1'b0; sat = 1'b1;
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        tick();
        check("clr_sf", {31'd0, sat_flag}, 32'd1);
        check("clr_pre", {24'd0, sat_count}, 32'd4);
        cnt_clr = 1'b1;
        tick();
        cnt_clr = 1'b0;
        check("clr_coincident", {24'd0, sat_count}, 32'd0);

        // 300 clamped results: counter sticks at 255
        a = 16'h0000; b = 16'h0001; sat = 1'b1; in_valid = 1'b1;
        for (int i = 0; i < 300; i++) tick();
        in_valid = 1'b0;
        tick(); tick(); tick();
        check("count_sticky", {24'd0, sat_count}, 32'd255);

        // Reset with two operations in flight
        a = 16'h4000; b = 16'h0001; sat = 1'b0; in_valid = 1'b1;
        tick();
        a = 16'h5000;
        tick();
        in_valid = 1'b0;
        check("flight_vld", {31'd0, out_valid}, 32'd1);
        rst = 1'b1;
        #1;
        check("flight_rst_in_ready", {31'd0, in_ready}, 32'd0);
        tick();
        rst = 1'b0;
        check("flight_rst_vld",   {31'd0, out_valid}, 32'd0);
        check("flight_rst_r",     {16'd0, r},         32'd0);
        check("flight_rst_count", {24'd0, sat_count}, 32'd0);
        for (int i = 0; i < 4; i++) begin
            tick();
            check($sformatf("flight_gone_%0d", i), {31'd0, out_valid}, 32'd0);
        end

        // Pipeline still works after mid-stream reset
        run_op("post_rst", 16'h8000, 16'h0001, 1'b0, 1'b1, 1'b0, 1'b0, 16'h7FFF, 1'b0, 1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
